// File: rtl/radix_dif_bfly_pkg.sv
// Shared payload type and fixed-point helpers for the radix-2 DIF butterfly.
// Defining RADIX_DIF_ROUND_EN switches shifted paths from floor to round-half-up.
package radix_dif_bfly_pkg;

  // Payload fields are sized for the widest supported build (bit_width <= 24,
  // bit_width_tw_factor <= 16) and carry sign-extended values.
  localparam int MAX_BW = 24;
  localparam int MAX_TW = 16;
  localparam int SD_W   = MAX_BW + 1;
  localparam int PR_W   = SD_W + MAX_TW;

`ifdef RADIX_DIF_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct packed {
    logic signed [SD_W-1:0]   sum_re;
    logic signed [SD_W-1:0]   sum_im;
    logic signed [SD_W-1:0]   dif_re;
    logic signed [SD_W-1:0]   dif_im;
    logic signed [MAX_TW-1:0] cos_w;
    logic signed [MAX_TW-1:0] sin_w;
    logic                     inverse;
  } stage_pl_t;

  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_fn = hi;
    else if (v < lo) sat_fn = lo;
    else             sat_fn = v;
  endfunction

  function automatic logic signed [63:0] rnd_ofs(input int sh);
    if (ROUND_EN && (sh > 0)) rnd_ofs = 64'sd1 <<< (sh - 1);
    else                      rnd_ofs = '0;
  endfunction

  function automatic logic signed [63:0] shift_rnd(input logic signed [63:0] v, input int sh);
    shift_rnd = (v + rnd_ofs(sh)) >>> sh;
  endfunction

endpackage

// File: rtl/radix_dif_rot.sv
// Twiddle rotation for the o2 path: S2 registers the four partial products,
// S3 combines, shifts, rounds and saturates one complex value.
module radix_dif_rot
  import radix_dif_bfly_pkg::*;
#(
  parameter int bit_width           = 16,
  parameter int bit_width_tw_factor = 8,
  parameter int SCALE               = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ld2_i,
  input  logic                     ld3_i,
  input  logic signed [SD_W-1:0]   dr_i,
  input  logic signed [SD_W-1:0]   di_i,
  input  logic signed [MAX_TW-1:0] c_i,
  input  logic signed [MAX_TW-1:0] s_i,
  input  logic                     inv_i,
  output logic [bit_width-1:0]     re_o,
  output logic [bit_width-1:0]     im_o,
  output logic                     sat_o
);

  localparam int SH = bit_width_tw_factor - 2 + SCALE;

  logic signed [PR_W-1:0] p_rc_q, p_is_q, p_ic_q, p_rs_q;
  logic                   inv_q;
  logic signed [63:0]     re_acc, im_acc, re_sh, im_sh, re_sat, im_sat;

  // Inverse uses conj(W), which only flips the sign of the sin terms.
  always_comb begin
    re_acc = inv_q ? (64'(p_rc_q) + 64'(p_is_q)) : (64'(p_rc_q) - 64'(p_is_q));
    im_acc = inv_q ? (64'(p_ic_q) - 64'(p_rs_q)) : (64'(p_ic_q) + 64'(p_rs_q));
    re_sh  = shift_rnd(re_acc, SH);
    im_sh  = shift_rnd(im_acc, SH);
    re_sat = sat_fn(re_sh, bit_width);
    im_sat = sat_fn(im_sh, bit_width);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_rc_q <= '0;
      p_is_q <= '0;
      p_ic_q <= '0;
      p_rs_q <= '0;
      inv_q  <= 1'b0;
      re_o   <= '0;
      im_o   <= '0;
      sat_o  <= 1'b0;
    end else begin
      if (ld2_i) begin
        p_rc_q <= PR_W'(dr_i) * PR_W'(c_i);
        p_is_q <= PR_W'(di_i) * PR_W'(s_i);
        p_ic_q <= PR_W'(di_i) * PR_W'(c_i);
        p_rs_q <= PR_W'(dr_i) * PR_W'(s_i);
        inv_q  <= inv_i;
      end
      if (ld3_i) begin
        re_o  <= bit_width'(re_sat);
        im_o  <= bit_width'(im_sat);
        sat_o <= (re_sat != re_sh) || (im_sat != im_sh);
      end
    end
  end

endmodule

// File: rtl/radix_dif_bfly.sv
// Pipelined radix-2 DIF butterfly: o1 = (a+b)>>SCALE, o2 = rotated (a-b), 3 stages.
// Build option: RADIX_DIF_ROUND_EN gives round-half-up on shifted paths (floor otherwise).
module radix_dif_bfly
  import radix_dif_bfly_pkg::*;
#(
  parameter int bit_width           = 16,
  parameter int bit_width_tw_factor = 8,
  parameter int SCALE               = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           inverse,
  input  logic [bit_width_tw_factor-1:0] cos_data,
  input  logic [bit_width_tw_factor-1:0] sin_data,
  input  logic [bit_width-1:0]           Re_i1,
  input  logic [bit_width-1:0]           Im_i1,
  input  logic [bit_width-1:0]           Re_i2,
  input  logic [bit_width-1:0]           Im_i2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [bit_width-1:0]           Re_o1,
  output logic [bit_width-1:0]           Im_o1,
  output logic [bit_width-1:0]           Re_o2,
  output logic [bit_width-1:0]           Im_o2,
  output logic                           out_sat
);

  logic                   v1_q, v2_q, v3_q;
  logic                   ld1, ld2, ld3;
  stage_pl_t              s1_d, s1_q;
  logic signed [SD_W-1:0] sum2_re_q, sum2_im_q;
  logic [bit_width-1:0]   o1_re_q, o1_im_q;
  logic                   o1_sat_q, o2_sat;
  logic signed [63:0]     o1_re_sh, o1_im_sh, o1_re_sat, o1_im_sat;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. A stage loads when empty or when its successor loads, so bubbles
  // collapse and a stalled output freezes every full stage behind it.
  assign ld3       = !v3_q || out_ready;
  assign ld2       = !v2_q || ld3;
  assign ld1       = !v1_q || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_q;

  always_comb begin
    s1_d         = '0;
    s1_d.sum_re  = SD_W'($signed(Re_i1)) + SD_W'($signed(Re_i2));
    s1_d.sum_im  = SD_W'($signed(Im_i1)) + SD_W'($signed(Im_i2));
    s1_d.dif_re  = SD_W'($signed(Re_i1)) - SD_W'($signed(Re_i2));
    s1_d.dif_im  = SD_W'($signed(Im_i1)) - SD_W'($signed(Im_i2));
    s1_d.cos_w   = MAX_TW'($signed(cos_data));
    s1_d.sin_w   = MAX_TW'($signed(sin_data));
    s1_d.inverse = inverse;
  end

  always_comb begin
    o1_re_sh  = shift_rnd(64'(sum2_re_q), SCALE);
    o1_im_sh  = shift_rnd(64'(sum2_im_q), SCALE);
    o1_re_sat = sat_fn(o1_re_sh, bit_width);
    o1_im_sat = sat_fn(o1_im_sh, bit_width);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_q      <= '0;
      sum2_re_q <= '0;
      sum2_im_q <= '0;
      o1_re_q   <= '0;
      o1_im_q   <= '0;
      o1_sat_q  <= 1'b0;
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld1 && in_valid) s1_q <= s1_d;
      if (ld2 && v1_q) begin
        sum2_re_q <= s1_q.sum_re;
        sum2_im_q <= s1_q.sum_im;
      end
      if (ld3 && v2_q) begin
        o1_re_q  <= bit_width'(o1_re_sat);
        o1_im_q  <= bit_width'(o1_im_sat);
        o1_sat_q <= (o1_re_sat != o1_re_sh) || (o1_im_sat != o1_im_sh);
      end
    end
  end

  radix_dif_rot #(
    .bit_width           (bit_width),
    .bit_width_tw_factor (bit_width_tw_factor),
    .SCALE               (SCALE)
  ) u_rot (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ld2_i  (ld2 && v1_q),
    .ld3_i  (ld3 && v2_q),
    .dr_i   (s1_q.dif_re),
    .di_i   (s1_q.dif_im),
    .c_i    (s1_q.cos_w),
    .s_i    (s1_q.sin_w),
    .inv_i  (s1_q.inverse),
    .re_o   (Re_o2),
    .im_o   (Im_o2),
    .sat_o  (o2_sat)
  );

  assign Re_o1   = o1_re_q;
  assign Im_o1   = o1_im_q;
  assign out_sat = o1_sat_q || o2_sat;

endmodule

// File: tb/tb_radix_dif_bfly.sv
// Directed bench for radix_dif_bfly: SCALE=0 main instance plus a SCALE=1 instance
// for the scaled/rounded path. RADIX_DIF_ROUND_EN selects the rounded expectations.
module tb_radix_dif_bfly;

`ifdef RADIX_DIF_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, inverse;
  logic [7:0]  cos_data, sin_data;
  logic [15:0] Re_i1, Im_i1, Re_i2, Im_i2;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] Re_o1, Im_o1, Re_o2, Im_o2;
  logic        in_ready_s, out_valid_s, out_sat_s;
  logic [15:0] Re_o1_s, Im_o1_s, Re_o2_s, Im_o2_s;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] exp_q[$];
  logic [64:0] held_q;
  logic        stalled = 1'b0;

  radix_dif_bfly dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inverse(inverse),
    .cos_data(cos_data), .sin_data(sin_data),
    .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
    .out_valid(out_valid), .out_ready(out_ready),
    .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2), .Im_o2(Im_o2), .out_sat(out_sat)
  );

  radix_dif_bfly #(.SCALE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .inverse(inverse),
    .cos_data(cos_data), .sin_data(sin_data),
    .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .Re_o1(Re_o1_s), .Im_o1(Im_o1_s), .Re_o2(Re_o2_s), .Im_o2(Im_o2_s), .out_sat(out_sat_s)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [64:0] ev(input int r1, input int i1, input int r2, input int i2, input bit s);
    return {16'(r1), 16'(i1), 16'(r2), 16'(i2), s};
  endfunction

  function automatic logic [64:0] obs();
    return {Re_o1, Im_o1, Re_o2, Im_o2, out_sat};
  endfunction

  function automatic logic [64:0] obs_s();
    return {Re_o1_s, Im_o1_s, Re_o2_s, Im_o2_s, out_sat_s};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs_v, input logic [65:0] exp_v);
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs_v, exp_v);
    end
  endtask

  // Driver tasks
  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int c, input int s, input bit inv);
    Re_i1 = 16'(ar); Im_i1 = 16'(ai); Re_i2 = 16'(br); Im_i2 = 16'(bi);
    cos_data = 8'(c); sin_data = 8'(s); inverse = inv;
    in_valid = 1'b1;
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int c, input int s, input bit inv, input logic [64:0] exp_v);
    drive(ar, ai, br, bi, c, s, inv);
    #1;
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(negedge clk);
      #1;
    end
    chk("accept", 66'(in_ready), 66'(1'b1));
    if (in_ready) begin
      @(posedge clk);
      exp_q.push_back(exp_v);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_i(input int i);
    send(10 * i, -i, i, 2, 64, 0, 1'b0, ev(11 * i, 2 - i, 9 * i, -i - 2, 1'b0));
  endtask

  // Called at the negedge after the accepting edge N; the pair is presented at
  // the output (handshake edge N+3) from the negedge after edge N+2.
  task automatic expect_latency(input string tag);
    #1 chk({tag, "_lat0"}, 66'(out_valid), 66'(1'b0));
    @(negedge clk);
    #1 chk({tag, "_lat1"}, 66'(out_valid), 66'(1'b0));
    @(negedge clk);
    #1 chk({tag, "_lat2"}, 66'(out_valid), 66'(1'b1));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    #3 chk(tag, 66'(exp_q.size()), 66'(0));
  endtask

  // Scoreboard: ordered expected queue, plus hold checks while stalled
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_hold", {out_valid, obs()}, {1'b1, held_q});
      if (out_valid && !out_ready) begin
        stalled = 1'b1;
        held_q  = obs();
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_out: observed %h, expected no output", obs());
        end
        if (exp_q.size() > 0) chk("out_data", 66'(obs()), 66'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inverse = 1'b0;
    cos_data = '0; sin_data = '0; Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {out_valid, obs()}, 66'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_reset", 66'(in_ready), 66'(1'b1));

    send(100, 0, 20, 0, 64, 0, 1'b0, ev(120, 0, 80, 0, 1'b0));
    expect_latency("basic");
    send(100, 0, 20, 0, 0, 64, 1'b0, ev(120, 0, 0, 80, 1'b0));
    expect_latency("rot_fwd");
    send(100, 0, 20, 0, 0, 64, 1'b1, ev(120, 0, 0, -80, 1'b0));
    expect_latency("rot_inv");
    send(32767, -32768, 32767, -32768, 64, 0, 1'b0, ev(32767, -32768, 0, 0, 1'b1));
    expect_latency("sat");
    send(1, 1, 1, 1, 64, 0, 1'b0, ev(2, 2, 0, 0, 1'b0));
    expect_latency("no_sat");

    // Back-to-back: general twiddle, conjugate, o2 rounding and negative difference
    send(10, 20, 4, 6, 45, -45, 1'b0, ev(14, 26, 14, RND ? 6 : 5, 1'b0));
    send(10, 20, 4, 6, 45, -45, 1'b1, ev(14, 26, -6, 14, 1'b0));
    send(1, 0, 0, 0, 32, 0, 1'b0, ev(1, 0, RND ? 1 : 0, 0, 1'b0));
    send(0, 0, 50, -30, 64, 0, 1'b0, ev(50, -30, -50, 30, 1'b0));
    drain("stream_drain");

    // SCALE=1 instance: halves both outputs, rounding only under the build option
    send(3, 0, 0, 0, 64, 0, 1'b0, ev(3, 0, 3, 0, 1'b0));
    expect_latency("scale_pos");
    chk("scale_pos_data", 66'(obs_s()), 66'(ev(RND ? 2 : 1, 0, RND ? 2 : 1, 0, 1'b0)));
    send(-3, 0, 0, 0, 64, 0, 1'b0, ev(-3, 0, -3, 0, 1'b0));
    expect_latency("scale_neg");
    chk("scale_neg_data", 66'(obs_s()), 66'(ev(RND ? -1 : -2, 0, RND ? -1 : -2, 0, 1'b0)));
    drain("scale_drain");

    // Backpressure: three pairs fill the pipe, a fourth waits with junk twiddles
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_i(i);
    drive(40, -4, 4, 2, 0, 64, 1'b1);
    #1 chk("bp_ready_low", 66'(in_ready), 66'(1'b0));
    chk("bp_out_valid", 66'(out_valid), 66'(1'b1));
    repeat (3) begin
      @(negedge clk);
      #1 chk("bp_ready_hold", 66'(in_ready), 66'(1'b0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 4; i <= 6; i++) send_i(i);
    drain("bp_drain");

    // Reset with three pairs in flight, then a fresh pair
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) send_i(i);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk("mid_reset_outputs", {out_valid, obs()}, 66'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_i(10);
    expect_latency("post_reset");
    drain("post_reset_drain");
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radix_dif_bfly.md
# radix_dif_bfly

Pipelined radix-2 decimation-in-frequency butterfly with a valid/ready stream interface. It forms the sum of two complex samples directly and the twiddle-rotated difference of the same pair, with a selectable conjugate twiddle for inverse transforms. It pairs with the existing combinational decimation-in-time butterfly: a DIT forward path feeds a DIF inverse path, or the reverse. It sits between the stage sample buffers and the stage output buffers, and absorbs downstream backpressure.

## Interface
Parameters:
- bit_width, 16, sample component width (signed two's complement)
- bit_width_tw_factor, 8, twiddle component width; 1.0 = 2^(bit_width_tw_factor-2)
- SCALE, 0, 1 = divide both outputs by 2 (per-stage scaling), 0 = no scaling

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts input this cycle
- inverse  in  1  1 = use conjugate twiddle; sampled with the input pair
- cos_data, sin_data  in  bit_width_tw_factor  twiddle W = cos + j·sin
- Re_i1, Im_i1, Re_i2, Im_i2  in  bit_width  input samples a, b
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts
- Re_o1, Im_o1, Re_o2, Im_o2  out  bit_width  outputs o1, o2
- out_sat  out  1  saturation occurred in this output pair

## Operation
- o1 = (a + b) >> SCALE
- o2 = ((a − b)·W) >> (bit_width_tw_factor − 2 + SCALE)
- W is replaced by conj(W) when inverse = 1.
- Forward rotation: re = dr·c − di·s, im = di·c + dr·s.
- Inverse rotation: re = dr·c + di·s, im = di·c − dr·s.
- Widths:
  - Sum and difference are bit_width+1 bits.
  - Each product is bit_width+1+bit_width_tw_factor bits.
  - Each product sum is bit_width+bit_width_tw_factor+2 bits. No intermediate truncation.
- Shifts are arithmetic. After shifting, each component saturates to [−2^(bit_width−1), 2^(bit_width−1)−1].
- out_sat = OR of the four component saturation events of that pair.
- Three register stages:
  - S1 registers sum, difference, twiddle and inverse.
  - S2 registers the four products.
  - S3 registers the shifted, rounded and saturated outputs.
- Each stage has its own valid bit. Stage k loads when it is empty or stage k+1 loads; S3 loads when empty or out_ready.
- in_ready = S1 loads. Bubbles collapse, so stages never hold duplicate data.
- Reset: all stage valids clear; out_valid, out_sat and all data outputs = 0; in_ready = 1 from the first cycle after reset deasserts. Reset asserted mid-stream discards all in-flight pairs.

## Timing
- Latency: 3 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+3, with no stalls.
- Throughput: one pair per cycle while out_ready = 1.
- Output data and out_sat stay stable while out_valid & !out_ready.
- With out_ready held low, at most 3 pairs are accepted; in_ready falls in the cycle the third pair occupies S1 while S2/S3 are full.
- Simultaneous out_ready and in_valid with a full pipe: one pair leaves and one enters in the same cycle, with no bubble.
- inverse, cos_data and sin_data are sampled only on acceptance. Changing them on stalled cycles has no effect.

## Configuration
- RADIX_DIF_ROUND_EN defined: every path with a nonzero shift adds 2^(shift−1) before shifting (round half up), then saturates.
- RADIX_DIF_ROUND_EN undefined: plain arithmetic shift (floor).
- The o1 path with SCALE = 0 never rounds.

## Structure
- Shared package holds:
  - the stage payload struct (sum, diff, twiddle, inverse)
  - the saturation function
  - the rounding-offset function
- One sub-module: radix_dif_rot, holding the S2 complex multiply plus the S3 shift, round and saturate for one complex value. It is instantiated once for the o2 path; o1 uses the shared functions inline.

## Test plan
- Basic (SCALE=0): a=(100,0), b=(20,0), W=(64,0) -> o1=(120,0), o2=(80,0), out_valid exactly 3 cycles after acceptance.
- Rotation: a=(100,0), b=(20,0), W=(0,64); inverse=0 -> o2=(0,80); inverse=1 -> o2=(0,−80).
- Saturation: a=b=(32767,−32768), W=(64,0) -> o1=(32767,−32768), out_sat=1; a=b=(1,1) -> out_sat=0.
- Rounding (SCALE=1): a=(3,0), b=(0,0), W=(64,0) -> o1=(2,0) with RADIX_DIF_ROUND_EN, (1,0) without.
- Backpressure: stream 6 distinct pairs with out_ready low for 5 cycles -> in_ready low after 3 accepted, all 6 outputs emitted in order, none lost or duplicated, outputs stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 pairs in flight -> outputs 0 and out_valid=0 immediately; after release, a new pair emerges correctly after 3 cycles with no stale data.
